// File: rtl/segre_cache_sa.sv
// Set-associative write-back data cache with tree-PLRU replacement and a line-granular memory port.
// Hits answer the cycle after acceptance; misses write back a dirty victim, refill, then answer.
package segre_cache_pkg;
  localparam int WORD_SIZE = 32;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memop_data_type_e;
endpackage

module segre_cache_sa
  import segre_cache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 4,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [WORD_SIZE-1:0]    req_addr_i,
  input  logic [WORD_SIZE-1:0]    req_data_i,
  input  memop_data_type_e        req_dtype_i,
  output logic                    rsp_valid_o,
  output logic [WORD_SIZE-1:0]    rsp_data_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    mem_req_valid_o,
  input  logic                    mem_req_ready_i,
  output logic                    mem_we_o,
  output logic [WORD_SIZE-1:0]    mem_addr_o,
  output logic [LINE_BYTES*8-1:0] mem_wline_o,
  input  logic                    mem_rsp_valid_i,
  input  logic [LINE_BYTES*8-1:0] mem_rline_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = WORD_SIZE - OFF_W - IDX_W;
  localparam int LW     = $clog2(WAYS);
  localparam int WAY_W  = (WAYS > 1) ? LW : 1;
  localparam int PW     = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int LINE_W = LINE_BYTES * 8;

  typedef enum logic [2:0] {IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FLUSH} state_e;

  state_e                        state_q;
  logic [WAYS-1:0][SETS-1:0]     valid_q, dirty_q;
  logic [SETS-1:0][PW-1:0]       plru_q;
  logic [TAG_W-1:0]              tag_q  [WAYS][SETS];
  logic [LINE_W-1:0]             line_q [WAYS][SETS];
  logic [WAY_W-1:0]              victim_q, fway_q;
  logic [IDX_W-1:0]              fset_q;
  logic                          miss_we_q;
  logic [WORD_SIZE-1:0]          miss_addr_q, miss_data_q;
  memop_data_type_e              miss_dtype_q;

  logic [IDX_W-1:0] req_idx, miss_idx;
  logic [TAG_W-1:0] req_tag, miss_tag;
  logic             accept, hit, inv_found;
  logic [WAY_W-1:0] hit_way, victim;

  assign req_idx  = req_addr_i[OFF_W +: IDX_W];
  assign req_tag  = req_addr_i[WORD_SIZE-1 -: TAG_W];
  assign miss_idx = miss_addr_q[OFF_W +: IDX_W];
  assign miss_tag = miss_addr_q[WORD_SIZE-1 -: TAG_W];

  assign req_ready_o = (state_q == IDLE) && !flush_i && !rst_i;
  assign accept      = req_valid_i && req_ready_o;

  function automatic logic [WORD_SIZE-1:0] load_word(input logic [LINE_W-1:0] line,
      input logic [WORD_SIZE-1:0] addr, input memop_data_type_e dt);
    logic [WORD_SIZE-1:0] w;
    w = line[(int'(addr[OFF_W-1:0]) >> 2) * 32 +: 32];
    case (dt)
      BYTE:    return {24'b0, w[8 * int'(addr[1:0]) +: 8]};
      HALF:    return {16'b0, w[16 * int'(addr[1]) +: 16]};
      default: return w;
    endcase
  endfunction

  function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
      input logic [WORD_SIZE-1:0] addr, input logic [WORD_SIZE-1:0] data, input memop_data_type_e dt);
    logic [LINE_W-1:0] r;
    int                base;
    r    = line;
    base = (int'(addr[OFF_W-1:0]) >> 2) * 32;
    case (dt)
      BYTE:    r[base + 8 * int'(addr[1:0]) +: 8]  = data[7:0];
      HALF:    r[base + 16 * int'(addr[1]) +: 16]  = data[15:0];
      default: r[base +: 32]                       = data;
    endcase
    return r;
  endfunction

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2; a 1 points to the upper half.
  function automatic logic [PW-1:0] plru_touch(input logic [PW-1:0] t, input logic [WAY_W-1:0] w);
    logic [PW-1:0] r;
    int            node;
    r    = t;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      r[node] = ~w[LW-1-l];
      node    = 2 * node + 1 + int'(w[LW-1-l]);
    end
    return r;
  endfunction

  function automatic logic [WAY_W-1:0] plru_victim(input logic [PW-1:0] t);
    logic [WAY_W-1:0] v;
    int               node;
    v    = '0;
    node = 0;
    for (int l = 0; l < LW; l++) begin
      v[LW-1-l] = t[node];
      node      = 2 * node + 1 + int'(t[node]);
    end
    return v;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    victim    = plru_victim(plru_q[req_idx]);
    inv_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inv_found && !valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        victim    = WAY_W'(w);
      end
    end
  end

  always_comb begin
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wline_o     = '0;
    case (state_q)
      WRITEBACK: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = 1'b1;
        mem_addr_o      = {tag_q[victim_q][miss_idx], miss_idx, {OFF_W{1'b0}}};
        mem_wline_o     = line_q[victim_q][miss_idx];
      end
      REFILL_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = {miss_addr_q[WORD_SIZE-1:OFF_W], {OFF_W{1'b0}}};
      end
      FLUSH: begin
        if (dirty_q[fway_q][fset_q]) begin
          mem_req_valid_o = 1'b1;
          mem_we_o        = 1'b1;
          mem_addr_o      = {tag_q[fway_q][fset_q], fset_q, {OFF_W{1'b0}}};
          mem_wline_o     = line_q[fway_q][fset_q];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      plru_q       <= '0;
      victim_q     <= '0;
      fway_q       <= '0;
      fset_q       <= '0;
      miss_we_q    <= 1'b0;
      miss_addr_q  <= '0;
      miss_data_q  <= '0;
      miss_dtype_q <= BYTE;
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      flush_done_o <= 1'b0;
      hit_cnt_o    <= '0;
      miss_cnt_o   <= '0;
    end else begin
      rsp_valid_o  <= 1'b0;
      rsp_data_o   <= '0;
      flush_done_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q <= FLUSH;
            fset_q  <= '0;
            fway_q  <= '0;
          end else if (accept) begin
            if (hit) begin
              rsp_valid_o        <= 1'b1;
              rsp_data_o         <= req_we_i ? '0 : load_word(line_q[hit_way][req_idx], req_addr_i, req_dtype_i);
              plru_q[req_idx]    <= plru_touch(plru_q[req_idx], hit_way);
              hit_cnt_o          <= sat_inc(hit_cnt_o);
              if (req_we_i) dirty_q[hit_way][req_idx] <= 1'b1;
            end else begin
              miss_we_q    <= req_we_i;
              miss_addr_q  <= req_addr_i;
              miss_data_q  <= req_data_i;
              miss_dtype_q <= req_dtype_i;
              victim_q     <= victim;
              miss_cnt_o   <= sat_inc(miss_cnt_o);
              state_q      <= (valid_q[victim][req_idx] && dirty_q[victim][req_idx]) ? WRITEBACK : REFILL_REQ;
            end
          end
        end
        WRITEBACK:  if (mem_req_ready_i) state_q <= REFILL_REQ;
        REFILL_REQ: if (mem_req_ready_i) state_q <= REFILL_WAIT;
        REFILL_WAIT: begin
          if (mem_rsp_valid_i) begin
            valid_q[victim_q][miss_idx] <= 1'b1;
            dirty_q[victim_q][miss_idx] <= miss_we_q;
            plru_q[miss_idx]            <= plru_touch(plru_q[miss_idx], victim_q);
            rsp_valid_o                 <= 1'b1;
            rsp_data_o                  <= miss_we_q ? '0 : load_word(mem_rline_i, miss_addr_q, miss_dtype_q);
            state_q                     <= IDLE;
          end
        end
        FLUSH: begin
          // Clean entries advance immediately; dirty ones wait for the writeback handshake.
          if (!dirty_q[fway_q][fset_q] || mem_req_ready_i) begin
            dirty_q[fway_q][fset_q] <= 1'b0;
            if (fway_q == WAY_W'(WAYS - 1)) begin
              fway_q <= '0;
              if (fset_q == IDX_W'(SETS - 1)) begin
                flush_done_o <= 1'b1;
                state_q      <= IDLE;
              end else begin
                fset_q <= fset_q + 1'b1;
              end
            end else begin
              fway_q <= fway_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data arrays need no reset: the valid bits gate every use.
  always_ff @(posedge clk_i) begin
    if (accept && hit && req_we_i)
      line_q[hit_way][req_idx] <= merge_store(line_q[hit_way][req_idx], req_addr_i, req_data_i, req_dtype_i);
    if (state_q == REFILL_WAIT && mem_rsp_valid_i && !rst_i) begin
      line_q[victim_q][miss_idx] <= miss_we_q ? merge_store(mem_rline_i, miss_addr_q, miss_data_q, miss_dtype_q)
                                              : mem_rline_i;
      tag_q[victim_q][miss_idx]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_segre_cache_sa.sv
// Directed bench for segre_cache_sa (2 ways, 4 sets, 16-byte lines) with response and memory scoreboards.
module tb_segre_cache_sa;
  import segre_cache_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, flush = 1'b0;
  logic [31:0] req_addr = '0, req_data = '0;
  memop_data_type_e req_dtype = WORD;
  logic req_ready, rsp_valid, flush_done, mem_req_valid, mem_we;
  logic [31:0] rsp_data, mem_addr, hit_cnt, miss_cnt;
  logic [127:0] mem_wline;
  logic mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [127:0] mem_rline = '0;

  segre_cache_sa #(.WAYS(2), .SETS(4), .LINE_BYTES(16)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_data_i(req_data), .req_dtype_i(req_dtype),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .flush_i(flush), .flush_done_o(flush_done),
    .mem_req_valid_o(mem_req_valid), .mem_req_ready_i(mem_req_ready), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wline_o(mem_wline),
    .mem_rsp_valid_i(mem_rsp_valid), .mem_rline_i(mem_rline),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic we; logic [31:0] addr; logic [127:0] wline; } mtxn_t;
  mtxn_t        exp_mem[$];
  logic [31:0]  exp_rsp[$];
  logic [127:0] mem [logic [31:0]];
  int n_checks = 0, n_fail = 0, mem_txns = 0, wb_txns = 0, done_pulses = 0, stall_left = 0;
  logic refill_due = 1'b0, hold_refill = 1'b0, spurious = 1'b0;
  logic [31:0] refill_addr = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic expect_mem(input logic we, input logic [31:0] addr, input logic [127:0] wline);
    mtxn_t t;
    t.we = we; t.addr = addr; t.wline = wline;
    exp_mem.push_back(t);
  endtask

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (flush_done) done_pulses++;
    if (rsp_valid) begin
      if (exp_rsp.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_rsp: got data 0x%0h with nothing outstanding", rsp_data);
      end else begin
        check("rsp_data", rsp_data, exp_rsp.pop_front());
      end
    end
  end

  // Memory responder and memory-request scoreboard
  initial forever begin
    mtxn_t t;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    if (spurious) begin
      mem_rsp_valid = 1'b1; mem_rline = '1; spurious = 1'b0;
    end else if (refill_due && !hold_refill) begin
      mem_rsp_valid = 1'b1; mem_rline = mem_read(refill_addr); refill_due = 1'b0;
    end else if (mem_req_valid) begin
      if (stall_left > 0) begin
        stall_left--;
        if (exp_mem.size() > 0) begin
          check("stall_addr", mem_addr, exp_mem[0].addr);
          if (exp_mem[0].we) check("stall_wline", mem_wline, exp_mem[0].wline);
        end
        check("stall_ready_low", req_ready, 0);
      end else begin
        mem_req_ready = 1'b1;
        mem_txns++;
        if (exp_mem.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_mem_req: we=%0d addr=0x%0h", mem_we, mem_addr);
        end else begin
          t = exp_mem.pop_front();
          check("mem_we", mem_we, t.we);
          check("mem_addr", mem_addr, t.addr);
          if (t.we) check("mem_wline", mem_wline, t.wline);
        end
        if (mem_we) begin
          wb_txns++; mem[mem_addr] = mem_wline;
        end else begin
          refill_due = 1'b1; refill_addr = mem_addr;
        end
      end
    end
  end

  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] data, input memop_data_type_e dt);
    int n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_data = data; req_dtype = dt;
    #1;
    while (!req_ready && n < 100) begin @(negedge clk); #1; n++; end
    if (n >= 100) begin n_checks++; n_fail++; $display("FAIL accept_timeout: addr 0x%0h", addr); end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] data,
                       input memop_data_type_e dt, input logic [31:0] exp, output int lat);
    exp_rsp.push_back(exp);
    send(we, addr, data, dt);
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (lat >= 200) begin n_checks++; n_fail++; $display("FAIL rsp_timeout: addr 0x%0h", addr); end
  endtask

  task automatic reset_now();
    rst = 1'b1;
    #1;
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
    exp_rsp.delete(); exp_mem.delete();
    stall_left = 0; refill_due = 1'b0; hold_refill = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    rst = 1'b0;
    #1;
    check("ready_after_release", req_ready, 1);
  endtask

  task automatic do_flush(input int exp_wb);
    int d0 = done_pulses, w0 = wb_txns, n = 0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("ready_low_flush_i", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    while (done_pulses == d0 && n < 200) begin @(negedge clk); #1; n++; end
    repeat (5) @(negedge clk);
    #1;
    check("flush_done_pulses", done_pulses, d0 + 1);
    check("flush_writebacks", wb_txns, w0 + exp_wb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, m0, n;
    mem[32'h40] = {32'h33333333, 32'h22222222, 32'h11111111, 32'hDEADBEEF};
    #1 rst = 1'b1;
    #1;
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_mem_req_valid", mem_req_valid, 0);
    check("reset_mem_addr", mem_addr, 0);
    check("reset_flush_done", flush_done, 0);
    check("reset_hit_cnt", hit_cnt, 0);
    check("reset_miss_cnt", miss_cnt, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_first_cycle", req_ready, 1);

    // Cold miss then hit
    expect_mem(1'b0, 32'h40, '0);
    issue(1'b0, 32'h40, 0, WORD, 32'hDEADBEEF, lat);
    check("cold_miss_latency", lat, 3);
    check("cold_miss_cnt", miss_cnt, 1);
    m0 = mem_txns;
    issue(1'b0, 32'h40, 0, WORD, 32'hDEADBEEF, lat);
    check("hit_latency", lat, 1);
    check("hit_no_mem", mem_txns, m0);
    check("hit_cnt_1", hit_cnt, 1);

    // Byte store merge, sub-word loads, back-to-back hits
    issue(1'b1, 32'h41, 32'h123456AB, BYTE, 32'h0, lat);
    check("store_hit_latency", lat, 1);
    issue(1'b0, 32'h40, 0, WORD, 32'hDEADABEF, lat);
    issue(1'b0, 32'h43, 0, HALF, 32'h0000DEAD, lat);
    issue(1'b0, 32'h46, 0, BYTE, 32'h00000011, lat);
    exp_rsp.push_back(32'hDEADABEF);
    exp_rsp.push_back(32'h11111111);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h40; req_dtype = WORD;
    @(negedge clk);
    req_addr = 32'h44;
    check("b2b_first_rsp", rsp_valid, 1);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b_second_rsp", rsp_valid, 1);
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h40, 0, WORD, 32'hDEADABEF, lat);
    check("spurious_rsp_ignored_no_mem", mem_txns, m0);
    check("hit_cnt_8", hit_cnt, 8);
    check("miss_cnt_still_1", miss_cnt, 1);

    // Dirty eviction: writeback of 0x040 precedes refill of 0x080, with a 10-cycle stall
    @(negedge clk); #2;
    reset_now();
    expect_mem(1'b0, 32'h000, '0);
    issue(1'b0, 32'h000, 0, WORD, 32'h0, lat);
    expect_mem(1'b0, 32'h040, '0);
    issue(1'b1, 32'h040, 32'h12345678, WORD, 32'h0, lat);
    issue(1'b0, 32'h000, 0, WORD, 32'h0, lat);
    expect_mem(1'b1, 32'h040, {32'h33333333, 32'h22222222, 32'h11111111, 32'h12345678});
    expect_mem(1'b0, 32'h080, '0);
    stall_left = 10;
    issue(1'b0, 32'h080, 0, WORD, 32'h00000080, lat);
    check("stall_consumed", stall_left, 0);
    check("evict_wb_count", wb_txns, 1);
    check("evict_miss_cnt", miss_cnt, 3);
    check("evict_hit_cnt", hit_cnt, 1);

    // Flush of two dirty lines
    issue(1'b1, 32'h000, 32'hA5A5A5A5, WORD, 32'h0, lat);
    expect_mem(1'b0, 32'h0A0, '0);
    issue(1'b1, 32'h0A6, 32'h1234BEEF, HALF, 32'h0, lat);
    expect_mem(1'b1, 32'h000, {32'h0000000C, 32'h00000008, 32'h00000004, 32'hA5A5A5A5});
    expect_mem(1'b1, 32'h0A0, {32'h000000AC, 32'h000000A8, 32'hBEEF00A4, 32'h000000A0});
    do_flush(2);
    m0 = mem_txns;
    issue(1'b0, 32'h000, 0, WORD, 32'hA5A5A5A5, lat);
    check("post_flush_hit0_latency", lat, 1);
    issue(1'b0, 32'h0A4, 0, WORD, 32'hBEEF00A4, lat);
    check("post_flush_hit1_latency", lat, 1);
    check("post_flush_no_mem", mem_txns, m0);
    do_flush(0);

    // Reset in REFILL_WAIT drops the miss; same address misses again
    @(negedge clk); #2;
    reset_now();
    hold_refill = 1'b1;
    expect_mem(1'b0, 32'h0C0, '0);
    send(1'b0, 32'h0C0, 0, WORD);
    n = 0;
    while (!refill_due && n < 50) begin @(negedge clk); #1; n++; end
    @(negedge clk); #2;
    check("refill_wait_ready_low", req_ready, 0);
    reset_now();
    expect_mem(1'b0, 32'h0C0, '0);
    issue(1'b0, 32'h0C0, 0, WORD, 32'h000000C0, lat);
    check("post_reset_miss_latency", lat, 3);
    check("post_reset_miss_cnt", miss_cnt, 1);

    // Reset while a refill request is stalled drops mem_req_valid_o immediately
    expect_mem(1'b0, 32'h100, '0);
    stall_left = 5;
    send(1'b0, 32'h100, 0, WORD);
    #2;
    check("stalled_req_valid", mem_req_valid, 1);
    reset_now();

    repeat (3) @(negedge clk);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    check("mem_queue_empty", exp_mem.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/segre_cache_sa.md
SEGRE_CACHE_SA -- requirements
Module: segre_cache_sa

Interface
REQ-001 Parameter WAYS, default 2, associativity; power of two, 1..8.
REQ-002 Parameter SETS, default 4, sets per way; power of two, >=2.
REQ-003 Parameter LINE_BYTES, default 16, line size in bytes; power of two, >=4.
REQ-004 clk_i  in  1  clock; the block SHALL use one clock.
REQ-005 rst_i  in  1  reset; the reset SHALL be asynchronous and active-high.
REQ-006 req_valid_i  in  1  core request valid.
REQ-007 req_ready_o  out  1  cache accepts the request this cycle.
REQ-008 req_we_i  in  1  1 store, 0 load.
REQ-009 req_addr_i  in  WORD_SIZE  byte address.
REQ-010 req_data_i  in  WORD_SIZE  store data, LSB-aligned.
REQ-011 req_dtype_i  in  memop_data_type_e  BYTE/HALF/WORD.
REQ-012 rsp_valid_o  out  1  one-cycle pulse: load data valid or store complete.
REQ-013 rsp_data_o  out  WORD_SIZE  load data, zero-extended; 0 for stores.
REQ-014 flush_i  in  1  write back all dirty lines; flush_done_o  out  1  one-cycle completion pulse.
REQ-015 mem_req_valid_o  out  1; mem_req_ready_i  in  1; mem_we_o  out  1 (1 writeback, 0 refill).
REQ-016 mem_addr_o  out  WORD_SIZE  line-aligned; mem_wline_o  out  LINE_BYTES*8  writeback line.
REQ-017 mem_rsp_valid_i  in  1  refill data valid; mem_rline_i  in  LINE_BYTES*8  refill line.
REQ-018 hit_cnt_o, miss_cnt_o  out  32 each  saturating performance counters.

Function
REQ-019 Address split SHALL be offset log2(LINE_BYTES) LSBs, index log2(SETS) bits above, tag the rest.
REQ-020 Per way/set: valid, dirty, tag, line; per set: WAYS-1 bit tree-PLRU (none when WAYS=1).
REQ-021 FSM states: IDLE, WRITEBACK, REFILL_REQ, REFILL_WAIT, FLUSH; req_ready_o SHALL be 1 only in IDLE with flush_i low.
REQ-022 Accept = req_valid_i && req_ready_o; tags compared in the accept cycle; hit -> rsp_valid_o next cycle; back-to-back hits at one per cycle.
REQ-023 Miss: request latched; victim = lowest-index invalid way, else PLRU way; victim valid&dirty -> WRITEBACK, else REFILL_REQ.
REQ-024 WRITEBACK: mem_req_valid_o=1, mem_we_o=1, addr {victim tag, index, 0}; addr/data stable until mem_req_ready_i; on handshake -> REFILL_REQ.
REQ-025 REFILL_REQ: mem_req_valid_o=1, mem_we_o=0, missed line address; on handshake -> REFILL_WAIT.
REQ-026 REFILL_WAIT: on mem_rsp_valid_i write line to victim, valid=1, tag set, store merged in same cycle (dirty=1, else 0); rsp_valid_o next cycle; -> IDLE.
REQ-027 mem_rsp_valid_i outside REFILL_WAIT SHALL be ignored.
REQ-028 Byte lanes: BYTE uses addr[1:0], HALF uses addr[1] (addr[0] ignored), WORD ignores addr[1:0].
REQ-029 PLRU SHALL update on every hit and every refill, pointing away from the accessed way.
REQ-030 Store hit sets dirty=1; load never changes dirty.
REQ-031 flush_i sampled in IDLE has priority over req_valid_i; FLUSH walks set 0..SETS-1, way 0..WAYS-1.
REQ-032 In FLUSH: dirty line -> writeback handshake as REQ-024, dirty cleared, valid kept; clean/invalid line -> one cycle skip.
REQ-033 After last entry flush_done_o pulses one cycle, FSM -> IDLE.
REQ-034 hit_cnt_o/miss_cnt_o increment per accepted hit/miss; SHALL saturate at 0xFFFF_FFFF.

Reset
REQ-035 rst_i SHALL immediately force IDLE, clear all valid/dirty/PLRU bits and counters, drop any memory transaction.
REQ-036 During reset: req_ready_o=0; all other outputs 0; req_ready_o=1 the first cycle after release.

Verification (WAYS=2, SETS=4, LINE_BYTES=16)
REQ-037 Cold load WORD 0x40, refill word0=0xDEADBEEF -> refill addr 0x40, rsp_data_o=0xDEADBEEF, miss_cnt_o=1; reload -> rsp next cycle, no mem request, hit_cnt_o=1.
REQ-038 Store BYTE 0xAB to 0x41, then load WORD 0x40 -> 0xDEADABEF, no mem traffic.
REQ-039 Load 0x000, store 0x040, load 0x000, load 0x080 -> writeback addr 0x040 precedes refill addr 0x080.
REQ-040 Two dirty lines then flush_i -> exactly two writes, one flush_done_o pulse; later loads to them hit.
REQ-041 mem_req_ready_i low 10 cycles in WRITEBACK -> mem_addr_o/mem_wline_o stable, req_ready_o=0 throughout.
REQ-042 rst_i asserted in REFILL_WAIT -> mem_req_valid_o=0 without a clock edge; same-address load after release misses.
